// File: rtl/row_integral_pkg.sv
// Shared types and width helpers for the Haar integral row stage.
package row_integral_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    // Window accumulator must hold WINDOW_WIDTH column sums without wrapping.
    function automatic int unsigned wsum_width(input int unsigned sum_w, input int unsigned win);
        return sum_w + $clog2(win);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row circular pixel delay: read-before-write at a pointer that wraps
// at FRAME_WIDTH-1 and restarts at 0 on start of frame.
module line_buffer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FRAME_WIDTH = 640,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                  clk_os,
    input  logic                  reset_os,
    input  logic                  wr_en,
    input  logic                  restart,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mem [FRAME_WIDTH];
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] addr_c;

    assign addr_c = restart ? '0 : ptr;

    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            ptr     <= '0;
            rd_data <= '0;
        end else if (wr_en) begin
            rd_data <= mem[addr_c];
            ptr     <= (addr_c == LAST_ADDR) ? '0 : addr_c + ADDR_WIDTH'(1);
        end
    end

    // Storage carries no reset; stale contents are masked by o_line_valid.
    always_ff @(posedge clk_os) begin
        if (wr_en) begin
            mem[addr_c] <= wr_data;
        end
    end

endmodule

// File: rtl/row_integral_window.sv
// Streaming row stage: column-sum cascade, per-row sliding window sum and
// one-row line buffer. Define ROW_INTEGRAL_OVF_EN for sticky overflow detection.
module row_integral_window
    import row_integral_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SUM_WIDTH    = 16,
    parameter int unsigned WINDOW_WIDTH = 24,
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned WSUM_WIDTH   = wsum_width(SUM_WIDTH, WINDOW_WIDTH)
) (
    input  logic                  clk_os,
    input  logic                  reset_os,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    input  logic [SUM_WIDTH-1:0]  in_col_sum,
    output logic [SUM_WIDTH-1:0]  o_col_sum,
    output logic [WSUM_WIDTH-1:0] o_window_sum,
    output logic                  o_window_valid,
    output logic [DATA_WIDTH-1:0] o_line_pixel,
    output logic                  o_line_valid,
    output logic                  o_out_valid,
    output logic [ADDR_WIDTH-1:0] o_col,
    output logic                  o_overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] WIN_LAST = ADDR_WIDTH'(WINDOW_WIDTH - 1);

    state_e                                  state;
    logic [ADDR_WIDTH-1:0]                   col_cnt;
    logic [WINDOW_WIDTH-1:0][SUM_WIDTH-1:0]  win_sr;

    logic                  accept_c;
    logic [ADDR_WIDTH-1:0] cur_col_c;
    logic [SUM_WIDTH-1:0]  col_sum_c;

    assign accept_c  = in_valid && (in_sof || (state != S_IDLE));
    assign cur_col_c = in_sof ? '0 : col_cnt;

`ifdef ROW_INTEGRAL_OVF_EN
    logic [SUM_WIDTH:0] full_sum_c;
    assign full_sum_c = (SUM_WIDTH+1)'(in_pixel) + (SUM_WIDTH+1)'(in_col_sum);
    assign col_sum_c  = full_sum_c[SUM_WIDTH-1:0];

    // Sticky carry flag; an accepted sof clears it unless that pixel overflows too.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            o_overflow <= 1'b0;
        end else if (accept_c) begin
            o_overflow <= full_sum_c[SUM_WIDTH] | (o_overflow & ~in_sof);
        end
    end
`else
    assign col_sum_c  = SUM_WIDTH'(in_pixel) + in_col_sum;
    assign o_overflow = 1'b0;
`endif

    // Row FSM, column tracking, window accumulator and registered outputs.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            state          <= S_IDLE;
            col_cnt        <= '0;
            win_sr         <= '0;
            o_window_sum   <= '0;
            o_col_sum      <= '0;
            o_col          <= '0;
            o_out_valid    <= 1'b0;
            o_window_valid <= 1'b0;
            o_line_valid   <= 1'b0;
        end else begin
            o_out_valid    <= accept_c;
            o_window_valid <= accept_c && (cur_col_c >= WIN_LAST);
            o_line_valid   <= accept_c && !in_sof && (state == S_RUN);
            if (accept_c) begin
                o_col     <= cur_col_c;
                o_col_sum <= col_sum_c;
                col_cnt   <= (cur_col_c == LAST_COL) ? '0 : cur_col_c + ADDR_WIDTH'(1);
                // Window never straddles rows: restart at every column 0.
                if (cur_col_c == '0) begin
                    win_sr       <= {{((WINDOW_WIDTH-1)*SUM_WIDTH){1'b0}}, col_sum_c};
                    o_window_sum <= WSUM_WIDTH'(col_sum_c);
                end else begin
                    win_sr       <= {win_sr[WINDOW_WIDTH-2:0], col_sum_c};
                    o_window_sum <= o_window_sum + WSUM_WIDTH'(col_sum_c)
                                    - WSUM_WIDTH'(win_sr[WINDOW_WIDTH-1]);
                end
                if (in_sof) begin
                    state <= S_FILL;
                end else if ((state == S_FILL) && (cur_col_c == LAST_COL)) begin
                    state <= S_RUN;
                end
            end
        end
    end

    line_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAME_WIDTH (FRAME_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_line_buffer (
        .clk_os   (clk_os),
        .reset_os (reset_os),
        .wr_en    (accept_c),
        .restart  (in_sof),
        .wr_data  (in_pixel),
        .rd_data  (o_line_pixel)
    );

endmodule

// File: tb/tb_row_integral_window.sv
// Directed, table-driven bench for row_integral_window (3-wide window, 8-pixel rows).
module tb_row_integral_window;

    localparam int unsigned DW  = 8;
    localparam int unsigned SW  = 8;
    localparam int unsigned WW  = 3;
    localparam int unsigned FW  = 8;
    localparam int unsigned AW  = 3;
    localparam int unsigned WSW = 10;
`ifdef ROW_INTEGRAL_OVF_EN
    localparam int OVF_ON = 1;
`else
    localparam int OVF_ON = 0;
`endif

    logic           clk_os = 1'b0;
    logic           reset_os = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [DW-1:0]  in_pixel = '0;
    logic [SW-1:0]  in_col_sum = '0;
    logic [SW-1:0]  o_col_sum;
    logic [WSW-1:0] o_window_sum;
    logic           o_window_valid;
    logic [DW-1:0]  o_line_pixel;
    logic           o_line_valid;
    logic           o_out_valid;
    logic [AW-1:0]  o_col;
    logic           o_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_os = ~clk_os;

    row_integral_window #(
        .DATA_WIDTH(DW), .SUM_WIDTH(SW), .WINDOW_WIDTH(WW),
        .FRAME_WIDTH(FW), .ADDR_WIDTH(AW), .WSUM_WIDTH(WSW)
    ) dut (
        .clk_os(clk_os), .reset_os(reset_os), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .in_col_sum(in_col_sum), .o_col_sum(o_col_sum),
        .o_window_sum(o_window_sum), .o_window_valid(o_window_valid),
        .o_line_pixel(o_line_pixel), .o_line_valid(o_line_valid),
        .o_out_valid(o_out_valid), .o_col(o_col), .o_overflow(o_overflow)
    );

    typedef struct {
        logic          v;
        logic          sof;
        logic [DW-1:0] px;
        logic [SW-1:0] cs;
        logic          ov;
        logic [AW-1:0] col;
        logic [SW-1:0] ocs;
        logic          wv;
        logic [WSW-1:0] ws;
        logic          lv;
        logic          lcare;
        logic [DW-1:0] lp;
    } vec_t;

    vec_t vecs[$];

    int r1_ws[8] = '{1, 3, 6, 9, 12, 15, 18, 21};
    int r2_ws[8] = '{10, 21, 33, 36, 39, 42, 45, 48};
    int r4_ws[5] = '{21, 43, 66, 69, 72};
    int r5_ws[8] = '{5, 11, 18, 21, 24, 27, 30, 33};

    function automatic void add(input int v, input int sof, input int px, input int cs,
                                input int ov, input int col, input int ocs, input int wv,
                                input int ws, input int lv, input int lcare, input int lp);
        vec_t t;
        t.v = v[0]; t.sof = sof[0]; t.px = DW'(px); t.cs = SW'(cs);
        t.ov = ov[0]; t.col = AW'(col); t.ocs = SW'(ocs); t.wv = wv[0];
        t.ws = WSW'(ws); t.lv = lv[0]; t.lcare = lcare[0]; t.lp = DW'(lp);
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %0d exp %0d", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        in_valid = t.v; in_sof = t.sof; in_pixel = t.px; in_col_sum = t.cs;
        @(posedge clk_os);
        #1;
        chk("out_valid", idx, 32'(o_out_valid), 32'(t.ov));
        chk("col", idx, 32'(o_col), 32'(t.col));
        chk("col_sum", idx, 32'(o_col_sum), 32'(t.ocs));
        chk("win_valid", idx, 32'(o_window_valid), 32'(t.wv));
        chk("win_sum", idx, 32'(o_window_sum), 32'(t.ws));
        chk("line_valid", idx, 32'(o_line_valid), 32'(t.lv));
        if (t.lcare) chk("line_pixel", idx, 32'(o_line_pixel), 32'(t.lp));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ov"}, 0, 32'(o_out_valid), 0);
        chk({name, "_col"}, 0, 32'(o_col), 0);
        chk({name, "_cs"}, 0, 32'(o_col_sum), 0);
        chk({name, "_wv"}, 0, 32'(o_window_valid), 0);
        chk({name, "_ws"}, 0, 32'(o_window_sum), 0);
        chk({name, "_lv"}, 0, 32'(o_line_valid), 0);
        chk({name, "_lp"}, 0, 32'(o_line_pixel), 0);
        chk({name, "_ovf"}, 0, 32'(o_overflow), 0);
    endtask

    task automatic step(input logic v, input logic sof, input int px, input int cs);
        vec_t t;
        t.v = v; t.sof = sof; t.px = DW'(px); t.cs = SW'(cs);
        in_valid = t.v; in_sof = t.sof; in_pixel = t.px; in_col_sum = t.cs;
        @(posedge clk_os);
        #1;
    endtask

    initial begin
        // Pixel without sof while idle is dropped
        add(1, 0, 9, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        // Row 1: sof + 1..8
        for (int i = 0; i < 8; i++)
            add(1, (i == 0) ? 1 : 0, i + 1, 0, 1, i, i + 1, (i >= 2) ? 1 : 0, r1_ws[i], 0, 0, 0);
        // Row 2: 10..17, line buffer returns row 1
        for (int i = 0; i < 8; i++)
            add(1, 0, 10 + i, 0, 1, i, 10 + i, (i >= 2) ? 1 : 0, r2_ws[i], 1, 1, i + 1);
        // Row 3: 1..8 with idle gaps carrying junk pixel and unqualified sof
        for (int i = 0; i < 8; i++) begin
            add(1, 0, i + 1, 0, 1, i, i + 1, (i >= 2) ? 1 : 0, r1_ws[i], 1, 1, 10 + i);
            if (i < 7) add(0, 1, 99, 55, 0, i, i + 1, 0, r1_ws[i], 0, 1, 10 + i);
        end
        // Row 4: nonzero cascade input, then sof at column 5
        for (int i = 0; i < 5; i++)
            add(1, 0, 20 + i, 1, 1, i, 21 + i, (i >= 2) ? 1 : 0, r4_ws[i], 1, 1, i + 1);
        for (int i = 0; i < 8; i++)
            add(1, (i == 0) ? 1 : 0, 5 + i, 0, 1, i, 5 + i, (i >= 2) ? 1 : 0, r5_ws[i], 0, 0, 0);
        add(1, 0, 50, 0, 1, 0, 50, 0, 50, 1, 1, 5);

        #12;
        chk_all_zero("reset");
        @(posedge clk_os);
        #1;
        reset_os = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);
        chk("ovf_small_sums", 0, 32'(o_overflow), 0);

        // Asynchronous reset mid-row
        step(1, 1, 1, 0);
        step(1, 0, 2, 0);
        step(1, 0, 3, 0);
        #2;
        reset_os = 1'b0;
        #1;
        chk_all_zero("async_rst");
        in_pixel = 4;
        @(posedge clk_os);
        #1;
        reset_os = 1'b1;
        begin
            vec_t t;
            t = '{v:1, sof:0, px:5, cs:0, ov:0, col:0, ocs:0, wv:0, ws:0, lv:0, lcare:1, lp:0};
            run_vec(t, 100);
            t = '{v:1, sof:1, px:7, cs:0, ov:1, col:0, ocs:7, wv:0, ws:7, lv:0, lcare:0, lp:0};
            run_vec(t, 101);
            // Carry out of the column sum
            t = '{v:1, sof:1, px:200, cs:100, ov:1, col:0, ocs:44, wv:0, ws:44, lv:0, lcare:0, lp:0};
            run_vec(t, 102);
            chk("ovf_set", 0, 32'(o_overflow), 32'(OVF_ON));
            t = '{v:1, sof:0, px:1, cs:0, ov:1, col:1, ocs:1, wv:0, ws:45, lv:0, lcare:0, lp:0};
            run_vec(t, 103);
            chk("ovf_hold", 0, 32'(o_overflow), 32'(OVF_ON));
            t = '{v:0, sof:0, px:0, cs:0, ov:0, col:1, ocs:1, wv:0, ws:45, lv:0, lcare:0, lp:0};
            run_vec(t, 104);
            chk("ovf_hold_idle", 0, 32'(o_overflow), 32'(OVF_ON));
            t = '{v:1, sof:1, px:1, cs:0, ov:1, col:0, ocs:1, wv:0, ws:1, lv:0, lcare:0, lp:0};
            run_vec(t, 105);
            chk("ovf_clear_sof", 0, 32'(o_overflow), 0);
        end

        in_valid = 1'b0;
        in_sof = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
